// File: rtl/clock_group_rst_seq_pkg.sv
// Shared types and elaboration helpers for the clock-group reset sequencer.
package clock_group_rst_seq_pkg;

  // Widest member index carried in the request bundle.
  localparam int MAX_IDX_W = 8;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_PULSE   = 2'd3
  } state_e;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] member;
    logic                 gate;
    logic                 en;
  } req_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clock_group_rst_seq_cycle_timer.sv
// Loadable down-counter shared by the hold, stagger and pulse intervals.
// After loading V, o_done is high on the V-th following edge.
module clock_group_cycle_timer
  import clock_group_rst_seq_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_busy,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority; otherwise count down to zero and park there.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/clock_group_rst_seq.sv
// Clock-group reset sequencer: holds all members in reset, releases them in
// staggered index order, then serves runtime clock-gate and reset-pulse
// requests for individual members.
module clock_group_rst_seq
  import clock_group_rst_seq_pkg::*;
#(
  parameter int N_MEMBERS      = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int STAGGER_CYCLES = 2,
  parameter int PULSE_CYCLES   = 4,
  parameter int IDX_W          = clog2_min1(N_MEMBERS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_req_valid,
  output logic                 io_req_ready,
  input  logic [IDX_W-1:0]     io_req_bits_member,
  input  logic                 io_req_bits_gate,
  input  logic                 io_req_bits_en,
  output logic [N_MEMBERS-1:0] io_out_reset,
  output logic [N_MEMBERS-1:0] io_out_clock_en,
  output logic                 io_ready
);

  localparam int CNT_W = clog2(max3(HOLD_CYCLES, STAGGER_CYCLES, PULSE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] C_HOLD    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] C_STAGGER = CNT_W'(STAGGER_CYCLES);
  localparam logic [CNT_W-1:0] C_PULSE   = CNT_W'(PULSE_CYCLES);

  state_e               r_state;
  logic [N_MEMBERS-1:0] r_rst;
  logic [N_MEMBERS-1:0] r_cen;
  logic [N_MEMBERS-1:0] r_saved;
  logic                 r_ready;
  logic                 r_req_ready;
  logic [IDX_W-1:0]     r_rel_idx;
  logic [IDX_W-1:0]     r_pulse_idx;

  req_t             w_req;
  logic             w_accept;
  logic             w_in_range;
  logic             w_load;
  logic [CNT_W-1:0] w_value;
  logic             w_busy;
  logic             w_done;

  assign w_req.member = MAX_IDX_W'(io_req_bits_member);
  assign w_req.gate   = io_req_bits_gate;
  assign w_req.en     = io_req_bits_en;
  assign w_accept     = io_req_valid && r_req_ready;
  assign w_in_range   = (int'(w_req.member) < N_MEMBERS);

  clock_group_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_load  (w_load),
    .i_value (w_value),
    .o_busy  (w_busy),
    .o_done  (w_done)
  );

  // Decide when the timer starts a new interval and how long it is.
  always_comb begin
    w_load  = 1'b0;
    w_value = '0;
    case (r_state)
      ST_HOLD: begin
        if (!w_busy) begin
          // First edge out of reset: start the hold interval.
          w_load  = 1'b1;
          w_value = C_HOLD;
        end else if (w_done && (N_MEMBERS > 1)) begin
          w_load  = 1'b1;
          w_value = C_STAGGER;
        end
      end
      ST_RELEASE: begin
        if (w_done && (int'(r_rel_idx) != N_MEMBERS - 1)) begin
          w_load  = 1'b1;
          w_value = C_STAGGER;
        end
      end
      ST_RUN: begin
        if (w_accept && w_in_range && !w_req.gate) begin
          w_load  = 1'b1;
          w_value = C_PULSE;
        end
      end
      default: begin
        w_load  = 1'b0;
        w_value = '0;
      end
    endcase
  end

  // Sequencer state, per-member reset/enable and the handshake flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_HOLD;
      r_rst       <= '1;
      r_cen       <= '1;
      r_saved     <= '1;
      r_ready     <= 1'b0;
      r_req_ready <= 1'b0;
      r_rel_idx   <= '0;
      r_pulse_idx <= '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (w_done) begin
            r_rst[0] <= 1'b0;
            if (N_MEMBERS == 1) begin
              r_state     <= ST_RUN;
              r_ready     <= 1'b1;
              r_req_ready <= 1'b1;
            end else begin
              r_state   <= ST_RELEASE;
              r_rel_idx <= IDX_W'(1);
            end
          end
        end
        ST_RELEASE: begin
          if (w_done) begin
            for (int k = 0; k < N_MEMBERS; k++) begin
              if (k == int'(r_rel_idx)) r_rst[k] <= 1'b0;
            end
            if (int'(r_rel_idx) == N_MEMBERS - 1) begin
              r_state     <= ST_RUN;
              r_ready     <= 1'b1;
              r_req_ready <= 1'b1;
            end else begin
              r_rel_idx <= r_rel_idx + 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Out-of-range members are consumed without any effect.
          if (w_accept && w_in_range) begin
            if (w_req.gate) begin
              for (int k = 0; k < N_MEMBERS; k++) begin
                if (k == int'(w_req.member)) begin
                  r_cen[k]   <= w_req.en;
                  r_saved[k] <= w_req.en;
                end
              end
            end else begin
              // Clock runs during the pulse so the member sees its reset.
              for (int k = 0; k < N_MEMBERS; k++) begin
                if (k == int'(w_req.member)) begin
                  r_rst[k] <= 1'b1;
                  r_cen[k] <= 1'b1;
                end
              end
              r_pulse_idx <= io_req_bits_member;
              r_ready     <= 1'b0;
              r_req_ready <= 1'b0;
              r_state     <= ST_PULSE;
            end
          end
        end
        ST_PULSE: begin
          if (w_done) begin
            for (int k = 0; k < N_MEMBERS; k++) begin
              if (k == int'(r_pulse_idx)) begin
                r_rst[k] <= 1'b0;
                r_cen[k] <= r_saved[k];
              end
            end
            r_ready     <= 1'b1;
            r_req_ready <= 1'b1;
            r_state     <= ST_RUN;
          end
        end
        default: r_state <= ST_HOLD;
      endcase
    end
  end

  assign io_out_reset    = r_rst;
  assign io_out_clock_en = r_cen;
  assign io_ready        = r_ready;
  assign io_req_ready    = r_req_ready;

endmodule
